// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width, sample type and DAC serializer state encoding.
package audio_pkg;
    localparam int DATA_W = 16;
    typedef logic signed [DATA_W-1:0] sample_t;
    typedef enum logic [1:0] {IDLE, WAIT_BCLK, SHIFT, PAD} dac_state_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous sample FIFO; a pop frees a slot for a push in the same cycle.
module audio_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: buffers mono samples and serializes them as I2S to a codec-mastered DAC.
// Define DAC_TX_STATS_EN to add saturating underflow/overflow event counters.
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int DATA_W     = audio_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1,
    localparam int BW        = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_aud_bclk,
    input  logic              i_aud_daclrck,
    output logic              o_aud_dacdat,
    output logic [CW-1:0]     o_fifo_count,
    output logic              o_underflow,
    output logic              o_overflow
`ifdef DAC_TX_STATS_EN
    ,
    output logic [15:0]       o_underflow_cnt,
    output logic [15:0]       o_overflow_cnt
`endif
);
    dac_state_t        state, state_next;
    logic [2:0]        bclk_sync, lr_sync;
    logic              bclk_fall, lr_fall, lr_rise, lr_edge, bit_tick, shifting;
    logic [DATA_W-1:0] shreg, shreg_next, hold, hold_next, fifo_rdata;
    logic [BW-1:0]     bit_cnt, bit_cnt_next;
    logic              dat_next, fifo_full, fifo_empty;

    // [0],[1] synchronize; [2] is history for edge detection
    assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
    assign lr_fall   = lr_sync[2] & ~lr_sync[1];
    assign lr_rise   = ~lr_sync[2] & lr_sync[1];
    assign lr_edge   = lr_fall | lr_rise;
    assign bit_tick  = bclk_fall & ~lr_edge;
    assign shifting  = bit_tick & (state == WAIT_BCLK || (state == SHIFT && bit_cnt != '0));

    audio_sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (i_valid),
        .pop   (lr_fall),
        .wdata (i_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fifo_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;

    always_comb
        state_next = lr_edge                                   ? WAIT_BCLK :
                     !bit_tick                                 ? state     :
                     state == WAIT_BCLK                        ? SHIFT     :
                     (state == SHIFT && bit_cnt == '0)         ? PAD       : state;

    // Frame edges preempt the shifter, so short codec frames restart cleanly.
    always_comb begin
        hold_next    = lr_fall ? (fifo_empty ? '0 : fifo_rdata) : hold;
        shreg_next   = lr_fall  ? hold_next :
                       lr_rise  ? hold      :
                       shifting ? shreg << 1 : shreg;
        dat_next     = shifting ? shreg[DATA_W-1] : bit_tick ? 1'b0 : o_aud_dacdat;
        bit_cnt_next = !shifting          ? bit_cnt           :
                       state == WAIT_BCLK ? BW'(DATA_W - 1)   : bit_cnt - 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            bclk_sync    <= '0;
            lr_sync      <= '0;
            shreg        <= '0;
            hold         <= '0;
            bit_cnt      <= '0;
            o_aud_dacdat <= 1'b0;
            o_underflow  <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            bclk_sync    <= {bclk_sync[1:0], i_aud_bclk};
            lr_sync      <= {lr_sync[1:0], i_aud_daclrck};
            shreg        <= shreg_next;
            hold         <= hold_next;
            bit_cnt      <= bit_cnt_next;
            o_aud_dacdat <= dat_next;
            o_underflow  <= lr_fall & fifo_empty;
            o_overflow   <= i_valid & fifo_full & ~lr_fall;
        end

`ifdef DAC_TX_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            o_underflow_cnt <= '0;
            o_overflow_cnt  <= '0;
        end else begin
            if (o_underflow && o_underflow_cnt != 16'hFFFF) o_underflow_cnt <= o_underflow_cnt + 1'b1;
            if (o_overflow && o_overflow_cnt != 16'hFFFF) o_overflow_cnt <= o_overflow_cnt + 1'b1;
        end
`endif
endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: drives codec-style I2S frames, predicts every sampled DAC bit from a
// queue model of the FIFO, and checks it in an independent BCLK-rising monitor.
module tb_audio_dac_tx;
    localparam int DEPTH = 4;

    logic        i_clk = 0, i_rst_n = 0, i_valid = 0;
    logic [15:0] i_data = '0;
    logic        bclk = 1, lrck = 0;
    logic        o_aud_dacdat, o_underflow, o_overflow;
    logic [2:0]  o_fifo_count;
`ifdef DAC_TX_STATS_EN
    logic [15:0] o_underflow_cnt, o_overflow_cnt;
`endif

    audio_dac_tx #(.DATA_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_aud_bclk     (bclk),
        .i_aud_daclrck  (lrck),
        .o_aud_dacdat   (o_aud_dacdat),
        .o_fifo_count   (o_fifo_count),
        .o_underflow    (o_underflow),
        .o_overflow     (o_overflow)
`ifdef DAC_TX_STATS_EN
        ,
        .o_underflow_cnt(o_underflow_cnt),
        .o_overflow_cnt (o_overflow_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int          total = 0, bad = 0;
    int          exp_un = 0, exp_ov = 0, un_seen = 0, ov_seen = 0;
    logic [15:0] model_q[$];
    logic [15:0] hold_m = '0;
    bit          exp_bits[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: the codec samples DACDAT on BCLK rising edges.
    always @(posedge bclk) begin
        if (exp_bits.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dacdat: bit %b with no expectation at %0t", o_aud_dacdat, $time);
        end else
            check("dacdat", 32'(o_aud_dacdat), 32'(exp_bits.pop_front()));
    end

    always @(negedge i_clk) begin
        if (o_underflow === 1'b1) un_seen++;
        if (o_overflow === 1'b1) ov_seen++;
    end

    function automatic void model_push(input logic [15:0] d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else exp_ov++;
    endfunction

    task automatic push(input logic [15:0] d);
        @(negedge i_clk);
        i_valid = 1;
        i_data  = d;
        @(negedge i_clk);
        i_valid = 0;
        model_push(d);
    endtask

    // One I2S half frame of 32 BCLKs; optional push coinciding with the left pop,
    // optional async reset after the rising BCLK of cycle rst_at.
    task automatic half_frame(input bit right, input bit edge_push, input logic [15:0] edge_d,
                              input int rst_at);
        logic [15:0] w;
        @(negedge i_clk);
        if (!right) begin
            if (model_q.size() != 0) w = model_q.pop_front();
            else begin
                w = '0;
                exp_un++;
            end
            hold_m = w;
            if (edge_push) model_push(edge_d);
        end else
            w = hold_m;
        for (int k = 0; k < 32; k++)
            exp_bits.push_back((rst_at > 0 && k > rst_at) ? 1'b0 :
                               (k >= 1 && k <= 16) ? w[16-k] : 1'b0);
        for (int k = 0; k < 32; k++) begin
            bclk = 0;
            if (k == 0) lrck = right;
            if (k == 0 && edge_push) begin
                #20 i_valid = 1;
                i_data = edge_d;
                #10 i_valid = 0;
                #20;
            end else
                #50;
            bclk = 1;
            if (k == 2 && !right) check("fifo_count", 32'(o_fifo_count), 32'(model_q.size()));
            if (rst_at > 0 && k == rst_at) begin
                #20 i_rst_n = 0;
                #1 check("rst_dacdat", 32'(o_aud_dacdat), 32'd0);
                check("rst_count", 32'(o_fifo_count), 32'd0);
                model_q.delete();
                hold_m = '0;
                #19 i_rst_n = 1;
                #10;
            end else
                #50;
        end
    endtask

    task automatic frame();
        half_frame(0, 0, '0, 0);
        half_frame(1, 0, '0, 0);
    endtask

    initial begin
        int ov0;
        repeat (3) @(negedge i_clk);
        check("reset_dacdat", 32'(o_aud_dacdat), 32'd0);
        check("reset_count", 32'(o_fifo_count), 32'd0);
        check("reset_underflow", 32'(o_underflow), 32'd0);
        check("reset_overflow", 32'(o_overflow), 32'd0);
        i_rst_n = 1;
        repeat (2) @(negedge i_clk);
        half_frame(1, 0, '0, 0);

        push(16'hA5C3);
        frame();

        push(16'h0001);
        push(16'h8000);
        push(16'h7FFF);
        check("count_after_3", 32'(o_fifo_count), 32'd3);
        repeat (3) frame();

        frame();
        check("underflow_pulses", 32'(un_seen), 32'(exp_un));
        push(16'h1234);
        frame();

        ov0 = ov_seen;
        for (int i = 0; i < 6; i++) push(16'($urandom));
        @(negedge i_clk);
        check("count_full", 32'(o_fifo_count), 32'd4);
        check("overflow_pulses", 32'(ov_seen - ov0), 32'd2);
`ifdef DAC_TX_STATS_EN
        check("overflow_cnt", 32'(o_overflow_cnt), 32'(exp_ov));
`endif

        ov0 = ov_seen;
        half_frame(0, 1, 16'hBEEF, 0);
        half_frame(1, 0, '0, 0);
        check("coincide_no_overflow", 32'(ov_seen - ov0), 32'd0);
        repeat (4) frame();

        push(16'hFFFF);
        push(16'h0F0F);
        half_frame(0, 0, '0, 8);
        half_frame(1, 0, '0, 0);
        push(16'h1357);
        frame();

        for (int i = 0; i < 12; i++) begin
            int n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) push(16'($urandom));
            frame();
        end

        repeat (5) @(negedge i_clk);
        check("bits_drained", 32'(exp_bits.size()), 32'd0);
        check("underflow_total", 32'(un_seen), 32'(exp_un));
        check("overflow_total", 32'(ov_seen), 32'(exp_ov));
`ifdef DAC_TX_STATS_EN
        check("underflow_cnt", 32'(o_underflow_cnt), 32'(exp_un));
        check("overflow_cnt_total", 32'(o_overflow_cnt), 32'(exp_ov));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/audio_dac_tx.md
Name: audio_dac_tx

Overview:
- Output stage directly downstream of the EQ effect: consumes its 16-bit signed sample stream (valid-strobed, one sample per audio frame) and serializes it to the WM8731 codec DAC in I2S format.
- Codec is bus master: BCLK and DACLRCK are inputs. The block buffers samples in a small FIFO, sends mono audio on both channels, and flags underflow and overflow.

Parameters:
- DATA_W, 16, sample width in bits; also the serialized word length.
- FIFO_DEPTH, 4, sample buffer entries; a power of two and at least 2.

Ports:
- i_clk  in  1  system clock; must be at least 8x BCLK frequency.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  one-cycle strobe; i_data is pushed into the FIFO.
- i_data  in  DATA_W  signed sample from the upstream effect stage.
- i_aud_bclk  in  1  codec bit clock (asynchronous to i_clk).
- i_aud_daclrck  in  1  codec DAC LR clock; low = left, high = right.
- o_aud_dacdat  out  1  serial DAC data.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_underflow  out  1  one-cycle pulse: the FIFO was empty at a left-frame start.
- o_overflow  out  1  one-cycle pulse: a push was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release): FIFO empty, o_fifo_count=0, o_aud_dacdat=0, o_underflow=0, o_overflow=0, shift register=0, FSM=IDLE.
- Synchronizers: BCLK and DACLRCK each pass through 2 flops plus 1 history flop. Edges are detected from the synchronized signals, so an edge is seen 2-3 i_clk cycles after the pin changes.
- FIFO push: on i_valid when not full. When full, the push is dropped and o_overflow pulses in the next cycle. A pop and a push in the same cycle while full are both accepted; the count stays the same.
- FSM states:
  - IDLE: exits to WAIT_BCLK on the first DACLRCK edge after reset.
  - WAIT_BCLK: the I2S one-bit delay slot.
  - SHIFT: drives the DATA_W bits.
  - PAD: drives 0 until the next frame edge.
- DACLRCK falling edge (left frame start), in any state:
  - If the FIFO is not empty: pop into sample_hold and the shift register.
  - If the FIFO is empty: load 0 and pulse o_underflow; sample_hold becomes 0.
  - Go to WAIT_BCLK.
- DACLRCK rising edge (right frame start), in any state: reload the shift register from sample_hold (mono duplicate, no pop). Go to WAIT_BCLK.
- A BCLK falling edge detected in the same cycle as a DACLRCK edge is not counted.
- WAIT_BCLK: on the next BCLK falling edge, drive bit DATA_W-1 and go to SHIFT with bit counter = DATA_W-1.
- SHIFT: on each BCLK falling edge, drive the next lower bit. After bit 0 has been driven, the next falling edge drives 0 and the FSM goes to PAD.
- Frame interruption: a frame edge arriving mid-SHIFT aborts the current word and restarts per the frame-edge rules (handles short codec frames).
- o_aud_dacdat changes only on detected BCLK falling edges or reset; it is held 0 in IDLE and PAD.
- Latency: a sample pushed before the synchronized left edge has its MSB driven at the first BCLK fall after that edge. Samples leave in FIFO order.

Optional Feature:
- DAC_TX_STATS_EN defined:
  - Adds outputs o_underflow_cnt[15:0] and o_overflow_cnt[15:0].
  - Each increments on its pulse and saturates at 16'hFFFF.
  - Reset clears both counters.
- DAC_TX_STATS_EN undefined: the counter outputs and logic are absent; the pulses are unchanged.

Decomposition:
- audio_pkg holds:
  - DATA_W default constant.
  - typedef sample_t (logic signed [DATA_W-1:0]).
  - typedef enum dac_state_t {IDLE, WAIT_BCLK, SHIFT, PAD}.
- One sub-module: audio_sample_fifo (synchronous FIFO with push, pop, full, empty and count; pop-before-push when full).

Test Plan:
- Push 16'hA5C3, then run one frame with BCLK=64*fs -> left and right words both serialize MSB-first as 1010_0101_1100_0011, MSB at the first BCLK fall after each LRCK edge, 0 otherwise.
- Push 3 samples 16'h0001, 16'h8000, 16'h7FFF -> the three left words appear in order; o_fifo_count goes 3, 2, 1, 0.
- Start a frame with the FIFO empty -> o_underflow pulses once, both channels serialize 16'h0000, and the next pushed sample appears in the following frame.
- Issue 6 i_valid strobes with FIFO_DEPTH=4 and no frames -> o_overflow pulses twice and o_fifo_count=4. With DAC_TX_STATS_EN defined, o_overflow_cnt=2.
- With the FIFO full, i_valid coincides with the pop at a left edge -> the push is accepted, o_fifo_count stays 4, no overflow.
- Assert i_rst_n low mid-SHIFT -> o_aud_dacdat=0 immediately. After release, the FSM waits in IDLE until the next LRCK edge and the FIFO is empty.
